// File: rtl/rr_mux_reg_pkg.sv
// Shared constants and width helper for the round-robin registered multiplexer.
package rr_mux_reg_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width for n channels, never less than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/rr_mux_reg_if.sv
// Producer/consumer bus of the registered multiplexer.
interface rr_mux_reg_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 4
) ();
  import rr_mux_reg_pkg::*;

  localparam int unsigned SEL_W = sel_width(N);

  logic [N*W-1:0]   I;
  logic [N-1:0]     I_VALID;
  logic [N-1:0]     I_READY;
  logic [SEL_W-1:0] S;
  logic             MODE;
  logic [W-1:0]     O;
  logic [SEL_W-1:0] O_SEL;
  logic             O_VALID;
  logic             O_READY;

  modport master (
    output I, I_VALID, S, MODE, O_READY,
    input  I_READY, O, O_SEL, O_VALID
  );

  modport slave (
    input  I, I_VALID, S, MODE, O_READY,
    output I_READY, O, O_SEL, O_VALID
  );

endinterface

// File: rtl/rr_mux_reg_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, modulo N.
module rr_arbiter
  import rr_mux_reg_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             gvalid
);

  logic [2*N-1:0] dbl;
  logic [SEL_W:0] sum;

  // Rotate requests so offset 0 is ptr, take the lowest offset, map back to an index.
  always_comb begin
    dbl = {req, req} >> ptr;
    sum = '0;
    for (int j = int'(N) - 1; j >= 0; j--) begin
      if (dbl[j]) sum = {1'b0, ptr} + (SEL_W+1)'(j);
    end
    if (sum >= (SEL_W+1)'(N)) sum = sum - (SEL_W+1)'(N);
    gvalid    = |req;
    grant_idx = sum[SEL_W-1:0];
    grant     = '0;
    for (int k = 0; k < int'(N); k++) begin
      grant[k] = gvalid && (grant_idx == SEL_W'(k));
    end
  end

endmodule

// File: rtl/rr_mux_reg.sv
// N-channel registered multiplexer with fixed-select or round-robin grant.
module rr_mux_reg
  import rr_mux_reg_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  rr_mux_reg_if.slave bus
);

  localparam int unsigned SEL_W = sel_width(N);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] ptr_next;
  logic [N-1:0]     rr_onehot;
  logic [N-1:0]     fix_onehot;
  logic [N-1:0]     sel_onehot;
  logic             rr_valid;
  logic             gvalid;
  logic             load;
  logic [W-1:0]     gdata;

  rr_arbiter #(.N(N)) u_arb (
    .req       (bus.I_VALID),
    .ptr       (ptr),
    .grant     (rr_onehot),
    .grant_idx (rr_idx),
    .gvalid    (rr_valid)
  );

  // Grant select; an out-of-range S matches no channel and so grants nothing.
  always_comb begin
    fix_onehot = '0;
    for (int k = 0; k < int'(N); k++) begin
      fix_onehot[k] = (bus.S == SEL_W'(k)) && bus.I_VALID[k];
    end
    if (bus.MODE == MODE_RR) begin
      sel_onehot = rr_onehot;
      grant_idx  = rr_idx;
    end else begin
      sel_onehot = fix_onehot;
      grant_idx  = bus.S;
    end
    gvalid = |sel_onehot;
    load   = !RESET && (!bus.O_VALID || bus.O_READY) && gvalid;
    bus.I_READY = load ? sel_onehot : '0;
  end

  // AND-OR data mux driven by the one-hot grant.
  always_comb begin
    gdata = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (sel_onehot[k]) gdata = gdata | bus.I[k*W +: W];
    end
  end

  assign ptr_next = (rr_idx == SEL_W'(N - 1)) ? '0 : rr_idx + SEL_W'(1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bus.O       <= '0;
      bus.O_SEL   <= '0;
      bus.O_VALID <= 1'b0;
      ptr         <= '0;
    end else if (load) begin
      bus.O       <= gdata;
      bus.O_SEL   <= grant_idx;
      bus.O_VALID <= 1'b1;
      if (bus.MODE == MODE_RR) ptr <= ptr_next;
    end else if (bus.O_READY) begin
      bus.O_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench for rr_mux_reg: vector table on a 4-channel instance, hand sequence on a 3-channel one.
module tb_rr_mux_reg;
  import rr_mux_reg_pkg::*;

  logic CLK = 1'b0;
  logic rst4;
  logic rst3;
  always #5 CLK = ~CLK;

  rr_mux_reg_if #(.N(4), .W(4)) if4 ();
  rr_mux_reg_if #(.N(3), .W(4)) if3 ();

  rr_mux_reg #(.N(4), .W(4)) dut4 (.CLK(CLK), .RESET(rst4), .bus(if4.slave));
  rr_mux_reg #(.N(3), .W(4)) dut3 (.CLK(CLK), .RESET(rst3), .bus(if3.slave));

  typedef struct {
    logic       rst;
    logic       mode;
    logic [1:0] s;
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_sel;
    logic [3:0] exp_o;
  } vec_t;

  localparam int NV = 27;
  vec_t vt [NV];

  int checks = 0;
  int errors = 0;

  function automatic vec_t row(logic rst, logic mode, logic [1:0] s, logic [3:0] vld, logic ordy,
                               logic [3:0] rdy, logic ov, logic [1:0] sel, logic [3:0] o);
    vec_t v;
    v.rst = rst; v.mode = mode; v.s = s; v.vld = vld; v.ordy = ordy;
    v.exp_rdy = rdy; v.exp_ov = ov; v.exp_sel = sel; v.exp_o = o;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // One cycle on the 3-channel instance: drive, check ready before the edge, outputs after.
  task automatic step3(int idx, logic rst, logic [1:0] s, logic [2:0] vld, logic ordy,
                       logic [2:0] rdy, logic ov, logic [1:0] sel, logic [3:0] o);
    @(negedge CLK);
    rst3 = rst; if3.MODE = MODE_FIXED; if3.S = s; if3.I_VALID = vld; if3.O_READY = ordy;
    #4;
    check("n3_i_ready", idx, 32'(if3.I_READY), 32'(rdy));
    @(posedge CLK);
    #1;
    check("n3_o_valid", idx, 32'(if3.O_VALID), 32'(ov));
    check("n3_o_sel",   idx, 32'(if3.O_SEL),   32'(sel));
    check("n3_o",       idx, 32'(if3.O),       32'(o));
  endtask

  initial begin
    rst4 = 1'b1; rst3 = 1'b1;
    if4.I = 16'h4321; if4.I_VALID = '0; if4.S = '0; if4.MODE = MODE_RR; if4.O_READY = 1'b1;
    if3.I = 12'h321;  if3.I_VALID = '0; if3.S = '0; if3.MODE = MODE_FIXED; if3.O_READY = 1'b1;

    // reset with every channel requesting
    vt[0] = row(1, 1, 0, 4'b1111, 1, 4'b0000, 0, 0, 4'h0);
    vt[1] = row(1, 1, 0, 4'b1111, 1, 4'b0000, 0, 0, 4'h0);
    // round-robin with all valid: 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++)
      vt[2+i] = row(0, 1, 0, 4'b1111, 1, 4'(4'b0001 << (i % 4)), 1, 2'(i % 4), 4'(i % 4 + 1));
    // fixed select S=2, then RR resumes at ptr=0
    vt[10] = row(0, 0, 2, 4'b1111, 1, 4'b0100, 1, 2, 4'h3);
    vt[11] = row(0, 1, 0, 4'b1111, 1, 4'b0001, 1, 0, 4'h1);
    // sparse requests and wrap-around
    vt[12] = row(0, 1, 0, 4'b0100, 1, 4'b0100, 1, 2, 4'h3);
    vt[13] = row(0, 1, 0, 4'b0010, 1, 4'b0010, 1, 1, 4'h2);
    vt[14] = row(0, 1, 0, 4'b1001, 1, 4'b1000, 1, 3, 4'h4);
    vt[15] = row(0, 1, 0, 4'b0011, 1, 4'b0001, 1, 0, 4'h1);
    // drain with nothing requesting, then idle
    vt[16] = row(0, 1, 0, 4'b0000, 1, 4'b0000, 0, 0, 4'h1);
    vt[17] = row(0, 1, 0, 4'b0000, 0, 4'b0000, 0, 0, 4'h1);
    // backpressure: load into empty register, hold three cycles, then drain+load
    vt[18] = row(0, 1, 0, 4'b1111, 0, 4'b0010, 1, 1, 4'h2);
    vt[19] = row(0, 1, 0, 4'b1111, 0, 4'b0000, 1, 1, 4'h2);
    vt[20] = row(0, 1, 0, 4'b1111, 0, 4'b0000, 1, 1, 4'h2);
    vt[21] = row(0, 1, 0, 4'b1111, 0, 4'b0000, 1, 1, 4'h2);
    vt[22] = row(0, 1, 0, 4'b1111, 1, 4'b0100, 1, 2, 4'h3);
    // fixed select of an idle channel: drain only
    vt[23] = row(0, 0, 1, 4'b1101, 1, 4'b0000, 0, 2, 4'h3);
    vt[24] = row(0, 1, 0, 4'b1111, 1, 4'b1000, 1, 3, 4'h4);
    // reset with a held word, then first grant goes to channel 0
    vt[25] = row(1, 1, 0, 4'b1111, 0, 4'b0000, 0, 0, 4'h0);
    vt[26] = row(0, 1, 0, 4'b1111, 1, 4'b0001, 1, 0, 4'h1);

    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      rst4 = vt[i].rst; if4.MODE = vt[i].mode; if4.S = vt[i].s;
      if4.I_VALID = vt[i].vld; if4.O_READY = vt[i].ordy;
      #4;
      check("i_ready", i, 32'(if4.I_READY), 32'(vt[i].exp_rdy));
      @(posedge CLK);
      #1;
      check("o_valid", i, 32'(if4.O_VALID), 32'(vt[i].exp_ov));
      check("o_sel",   i, 32'(if4.O_SEL),   32'(vt[i].exp_sel));
      check("o",       i, 32'(if4.O),       32'(vt[i].exp_o));
    end

    // N=3: S=3 is out of range and must never grant
    step3(0, 1, 3, 3'b111, 1, 3'b000, 0, 0, 4'h0);
    step3(1, 0, 3, 3'b111, 1, 3'b000, 0, 0, 4'h0);
    step3(2, 0, 3, 3'b111, 1, 3'b000, 0, 0, 4'h0);
    step3(3, 0, 2, 3'b111, 1, 3'b100, 1, 2, 4'h3);
    step3(4, 0, 3, 3'b111, 0, 3'b000, 1, 2, 4'h3);
    step3(5, 1, 2, 3'b111, 0, 3'b000, 0, 0, 4'h0);
    step3(6, 0, 0, 3'b111, 1, 3'b001, 1, 0, 4'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
